network_sequencer: RTL and testbench

NETWORK_SEQUENCER -- requirements
Module: network_sequencer

---
 rtl/network_seq_pkg.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/network_sequencer.sv | 125 ++++++++++++
 tb/tb_network_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_seq_pkg.sv
// Shared types and constants for the network sequencer: FSM states, default sizes,
// layer encodings and index-width helpers.
package network_seq_pkg;

    localparam int NUM_INPUTS_DEF   = 9;
    localparam int NUM_HL_NODES_DEF = 3;
    localparam int NUM_OL_NODES_DEF = 3;

    localparam logic LAYER_HIDDEN = 1'b0;
    localparam logic LAYER_OUTPUT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT_RES,
        FIN
    } seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Keeps index ports at least one bit wide when a dimension collapses to 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/network_sequencer.sv
// network_sequencer: walks every hidden node then every output node, feeding operands to a shared MAC.
// Define NETWORK_SEQ_PERF_EN to count busy cycles on `cycles`; otherwise `cycles` reads 0.
module network_sequencer
    import network_seq_pkg::*;
#(
    parameter int  NUM_INPUTS   = NUM_INPUTS_DEF,
    parameter int  NUM_HL_NODES = NUM_HL_NODES_DEF,
    parameter int  NUM_OL_NODES = NUM_OL_NODES_DEF,
    localparam int NODE_W       = idx_width(max2(NUM_HL_NODES, NUM_OL_NODES)),
    localparam int IN_W         = idx_width(max2(NUM_INPUTS, NUM_HL_NODES))
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mac_clear,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic              mac_last,
    output logic              layer_sel,
    output logic [NODE_W-1:0] node_idx,
    output logic [IN_W-1:0]   in_idx,
    input  logic              res_valid,
    output logic              res_we,
    output logic [31:0]       cycles
);

    seq_state_e        state;
    logic [IN_W-1:0]   fan_last;
    logic [NODE_W-1:0] node_last;

    // The output layer's fan-in is the hidden-node count.
    assign fan_last  = (layer_sel == LAYER_OUTPUT) ? IN_W'(NUM_HL_NODES - 1) : IN_W'(NUM_INPUTS - 1);
    assign node_last = (layer_sel == LAYER_OUTPUT) ? NODE_W'(NUM_OL_NODES - 1) : NODE_W'(NUM_HL_NODES - 1);

    assign mac_last = mac_valid && (in_idx == fan_last);
    assign res_we   = (state == WAIT_RES) && res_valid;

    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            layer_sel <= LAYER_HIDDEN;
            node_idx  <= '0;
            in_idx    <= '0;
        end else begin
            done      <= 1'b0;
            mac_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                        layer_sel <= LAYER_HIDDEN;
                        node_idx  <= '0;
                        in_idx    <= '0;
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    mac_valid <= 1'b1;
                end
                FEED: begin
                    if (mac_ready) begin
                        in_idx <= in_idx + IN_W'(1);
                        if (in_idx == fan_last) begin
                            state     <= WAIT_RES;
                            mac_valid <= 1'b0;
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        in_idx <= '0;
                        if (node_idx != node_last) begin
                            state     <= CLEAR;
                            mac_clear <= 1'b1;
                            node_idx  <= node_idx + NODE_W'(1);
                        end else if (layer_sel == LAYER_HIDDEN) begin
                            state     <= CLEAR;
                            mac_clear <= 1'b1;
                            layer_sel <= LAYER_OUTPUT;
                            node_idx  <= '0;
                        end else begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    layer_sel <= LAYER_HIDDEN;
                    node_idx  <= '0;
                    in_idx    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NETWORK_SEQ_PERF_EN
    logic accept_start;

    // Cleared only by a start the FSM actually takes, so the count survives DONE and ABORT.
    assign accept_start = (state == IDLE) && start && !abort;

    sat_counter #(.WIDTH(32)) u_perf (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (accept_start),
        .enable (busy),
        .count  (cycles)
    );
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: handshake and result-write scoreboards plus run-level counts.
`timescale 1ns/1ps
module tb_network_sequencer;

    localparam int PERF =
`ifdef NETWORK_SEQ_PERF_EN
        1;
`else
        0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mac_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic        busy, done, mac_clear, mac_valid, mac_last, layer_sel, res_we;
    logic [1:0]  node_idx;
    logic [3:0]  in_idx;
    logic [31:0] cycles;

    network_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mac_clear (mac_clear),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_last  (mac_last),
        .layer_sel (layer_sel),
        .node_idx  (node_idx),
        .in_idx    (in_idx),
        .res_valid (res_valid),
        .res_we    (res_we),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cyc(input int n);
        return (PERF != 0) ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] hs_word(input logic layer, input int node, input int idx, input logic last);
        return {24'd0, layer, 2'(node), 4'(idx), last};
    endfunction

    function automatic logic [31:0] we_word(input logic layer, input int node);
        return {29'd0, layer, 2'(node)};
    endfunction

    // Scoreboards: filled when a run is launched, drained by the monitor.
    logic [31:0] hs_q[$];
    logic [31:0] we_q[$];
    int n_busy = 0, n_clear = 0, n_hs = 0, n_hs_hidden = 0, n_we = 0, n_done = 0;

    always @(negedge clk) begin
        logic in_wait;
        in_wait = busy && !mac_valid && !mac_clear;
        if (busy)      n_busy++;
        if (mac_clear) n_clear++;
        if (done)      n_done++;
        if (mac_valid && mac_ready) begin
            n_hs++;
            if (!layer_sel) n_hs_hidden++;
            if (hs_q.size() == 0)
                check("hs_unexpected", {24'd0, layer_sel, node_idx, in_idx, mac_last}, 32'hFFFF_FFFF);
            else
                check("handshake", {24'd0, layer_sel, node_idx, in_idx, mac_last}, hs_q.pop_front());
        end
        if (in_wait)
            check("res_we_wait", {31'd0, res_we}, {31'd0, res_valid});
        else if (res_valid)
            check("res_we_ignored", {31'd0, res_we}, 32'd0);
        if (res_we) begin
            n_we++;
            if (we_q.size() == 0)
                check("res_we_unexpected", {31'd0, res_we}, 32'd0);
            else
                check("res_we_node", {29'd0, layer_sel, node_idx}, we_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        hs_q.delete();
        we_q.delete();
    endtask

    task automatic push_run();
        for (int l = 0; l < 2; l++) begin
            int fan;
            fan = (l == 0) ? 9 : 3;
            for (int n = 0; n < 3; n++) begin
                we_q.push_back(we_word(l[0], n));
                for (int i = 0; i < fan; i++)
                    hs_q.push_back(hs_word(l[0], n, i, i == fan - 1));
            end
        end
    endtask

    // One full run. stall_at>=0 holds mac_ready low 3 cycles at hidden node 0 / that index;
    // res_delay<0 keeps res_valid high, else delays it that many WAIT_RES cycles;
    // feed_pulse raises res_valid during FEED; restart_at re-asserts start on that cycle.
    task automatic run(input int stall_at, input int res_delay, input bit feed_pulse,
                       input int restart_at, output int done_at);
        int n, stall_cnt, wait_cnt;
        bit post_checked;
        logic in_wait;
        n = 0; stall_cnt = 0; wait_cnt = 0; post_checked = 0;
        done_at = -1;
        push_run();
        start = 1'b1;
        mac_ready = 1'b1;
        res_valid = (res_delay < 0);
        tick();
        start = 1'b0;
        n = 1;
        check("first_clear", {23'd0, mac_clear, busy, layer_sel, node_idx, in_idx},
              {23'd0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0});
        while (n < 400) begin
            if (done) begin
                done_at = n;
                break;
            end
            if (stall_cnt == 3 && !post_checked) begin
                post_checked = 1;
                check("stall_in_idx", {28'd0, in_idx}, 32'(stall_at));
                check("stall_node", {30'd0, node_idx}, 32'd0);
                check("stall_valid", {31'd0, mac_valid}, 32'd1);
            end
            mac_ready = 1'b1;
            if (stall_at >= 0 && stall_cnt < 3 && mac_valid && !layer_sel
                && node_idx == 2'd0 && in_idx == 4'(stall_at)) begin
                mac_ready = 1'b0;
                stall_cnt++;
            end
            in_wait = busy && !mac_valid && !mac_clear;
            if (res_delay < 0) begin
                res_valid = 1'b1;
            end else if (in_wait) begin
                res_valid = (wait_cnt >= res_delay);
                wait_cnt  = res_valid ? 0 : wait_cnt + 1;
            end else begin
                res_valid = feed_pulse && mac_valid && (in_idx == 4'd2);
            end
            start = (n == restart_at);
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    int s_busy, s_clear, s_hs, s_hid, s_we, s_done;
    task automatic snap();
        s_busy = n_busy; s_clear = n_clear; s_hs = n_hs;
        s_hid = n_hs_hidden; s_we = n_we; s_done = n_done;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, {25'd0, busy, done, mac_clear, mac_valid, mac_last, layer_sel, res_we}, 32'd0);
        check({tag, "_idx"}, {26'd0, node_idx, in_idx}, 32'd0);
    endtask

    initial begin
        int d, n;

        // Reset, with start held high throughout
        start = 1'b1;
        res_valid = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        check("reset_cycles", cycles, 32'd0);
        rstn = 1'b1;
        start = 1'b0;
        tick();
        check("reset_start_ignored", {31'd0, busy}, 32'd0);
        res_valid = 1'b0;
        tick();

        // Nominal run
        snap();
        run(-1, -1, 0, -1, d);
        check("nom_done_at", 32'(d), 32'd49);
        tick();
        check("nom_busy_cycles", 32'(n_busy - s_busy), 32'd48);
        check("nom_clears", 32'(n_clear - s_clear), 32'd6);
        check("nom_handshakes", 32'(n_hs - s_hs), 32'd36);
        check("nom_hidden_hs", 32'(n_hs_hidden - s_hid), 32'd27);
        check("nom_res_we", 32'(n_we - s_we), 32'd6);
        check("nom_done_pulses", 32'(n_done - s_done), 32'd1);
        check("nom_cycles", cycles, exp_cyc(48));
        check("nom_sb_empty", 32'(hs_q.size() + we_q.size()), 32'd0);
        res_valid = 1'b0;
        repeat (3) tick();
        check_idle("nom_after");
        check("nom_cycles_hold", cycles, exp_cyc(48));

        // Back-pressure at hidden in_idx 4
        snap();
        run(4, -1, 0, -1, d);
        check("stall_done_at", 32'(d), 32'd52);
        check("stall_cycles", cycles, exp_cyc(51));
        tick();
        check("stall_handshakes", 32'(n_hs - s_hs), 32'd36);
        res_valid = 1'b0;
        tick();

        // Result pulse during FEED, then 5-cycle result delay per node
        snap();
        run(-1, 5, 1, -1, d);
        check("delay_done_at", 32'(d), 32'd79);
        check("delay_cycles", cycles, exp_cyc(78));
        tick();
        check("delay_res_we", 32'(n_we - s_we), 32'd6);
        res_valid = 1'b0;
        tick();

        // Abort in FEED of hidden node 1
        push_run();
        start = 1'b1; mac_ready = 1'b1; res_valid = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(mac_valid && node_idx == 2'd1) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_node", {30'd0, node_idx}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flush();
        check_idle("abort");
        check("abort_cycles", cycles, exp_cyc(13));
        snap();
        repeat (5) tick();
        check("abort_no_done", 32'(n_done - s_done), 32'd0);
        check("abort_cycles_hold", cycles, exp_cyc(13));
        run(-1, -1, 0, -1, d);
        check("restart_done_at", 32'(d), 32'd49);
        check("restart_cycles", cycles, exp_cyc(48));
        tick();

        // Start while busy is ignored; start with abort stays idle
        run(-1, -1, 0, 10, d);
        check("rebusy_done_at", 32'(d), 32'd49);
        tick();
        res_valid = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort");
        tick();
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        check("start_abort_cycles", cycles, exp_cyc(48));

        // Reset during output-layer WAIT_RES
        push_run();
        start = 1'b1; mac_ready = 1'b1; res_valid = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(layer_sel && busy && !mac_valid && !mac_clear) && n < 100) begin
            res_valid = !layer_sel;
            tick();
            n++;
        end
        check("rst_reach_wait", {30'd0, layer_sel, mac_valid}, 32'd2);
        rstn = 1'b0;
        res_valid = 1'b1;
        tick();
        rstn = 1'b1;
        flush();
        check_idle("midrun_reset");
        check("midrun_reset_cycles", cycles, 32'd0);
        res_valid = 1'b0;
        tick();
        run(-1, -1, 0, -1, d);
        check("post_reset_done_at", 32'(d), 32'd49);
        check("post_reset_cycles", cycles, exp_cyc(48));
        tick();
        res_valid = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
